snapshot_sequencer: RTL and testbench
=====================================

SNAPSHOT_SEQUENCER -- requirements
Module: snapshot_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: the consecutive cycles a synchronised button level must hold before it is accepted (board builds override it to 1_000_000).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port btn_capture, input, 1 bit: raw asynchronous push-button; in LIVE it stores a snapshot, in REVIEW it steps to the next snapshot.
REQ-005 The block SHALL have port btn_mode, input, 1 bit: raw asynchronous push-button that toggles between LIVE and REVIEW.
REQ-006 The block SHALL have port sw, input, 8 bits: switch data.
REQ-007 The block SHALL have port led, output, 8 bits, registered: the displayed byte.
REQ-008 The block SHALL have port slot_idx, output, 2 bits, registered: the slot being written (LIVE) or displayed (REVIEW).
REQ-009 The block SHALL have port review, output, 1 bit, registered: 1 in REVIEW.
REQ-010 The block SHALL have port full, output, 1 bit, registered: 1 when all 4 slots hold valid data.

Function
REQ-011 Each button SHALL pass through a 2-flop synchroniser, then a debouncer holding a stable level.
REQ-012 The debouncer SHALL flip its stable level only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the count.
REQ-013 A single-cycle pulse (cap_p / mode_p) SHALL be generated on each stable 0->1 transition only; holding a button produces no further pulses.
REQ-014 Storage SHALL be 4 slots x 8 bits, plus wr_ptr (2 bits), count (0..4, 3 bits) and rd_ptr (2 bits).
REQ-015 Oldest slot SHALL be defined as (wr_ptr - count) mod 4.
REQ-016 The FSM SHALL have exactly two states, LIVE and REVIEW.
REQ-017 In LIVE, led SHALL register sw every cycle (1-cycle latency) and slot_idx SHALL equal wr_ptr.
REQ-018 In LIVE on cap_p, the block SHALL write sw into slot[wr_ptr], set wr_ptr to wr_ptr+1 mod 4, and set count to min(count+1, 4).
REQ-019 Capture when count=4 SHALL overwrite the oldest slot (ring behaviour) with count held at 4.
REQ-020 In LIVE on mode_p with count>0, the FSM SHALL go to REVIEW and load rd_ptr with the oldest slot.
REQ-021 In LIVE on mode_p with count=0, the FSM SHALL stay in LIVE with no other effect.
REQ-022 In REVIEW, led SHALL equal slot[rd_ptr] and slot_idx SHALL equal rd_ptr, both registered.
REQ-023 In REVIEW, sw changes SHALL NOT affect led.
REQ-024 In REVIEW on cap_p, rd_ptr SHALL advance by 1 mod 4, except that stepping past the newest slot ((wr_ptr-1) mod 4) SHALL wrap to the oldest, so only valid slots are shown.
REQ-025 In REVIEW on mode_p, the FSM SHALL return to LIVE; stored slots, wr_ptr and count SHALL be preserved.
REQ-026 If cap_p and mode_p are asserted in the same cycle, mode_p SHALL take priority and cap_p SHALL be discarded.
REQ-027 full SHALL equal (count==4) and review SHALL equal (state==REVIEW), both registered.

Reset
REQ-028 While rst=1 on a clock edge, the block SHALL enter LIVE and clear led, slot_idx, review, full, wr_ptr, rd_ptr, count, the synchroniser flops, the debounce counters and the stable levels to 0.
REQ-029 Slot contents need not be cleared, but SHALL be treated as invalid through count=0.
REQ-030 Reset asserted mid-debounce or in REVIEW SHALL abort the operation; no pulse SHALL be emitted in the cycle following reset release.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Test: reset, then sw=0xA5 for 3 cycles -> led=0x00 during reset and 0xA5 one cycle after sw is applied post-reset; review=0, full=0.
REQ-032 Test: glitch btn_capture high for 3 cycles, then low -> no capture, and wr_ptr/slot_idx stay 0; holding it high for 10 cycles -> exactly one capture and slot_idx=1.
REQ-033 Test: capture 0x11, 0x22, 0x33, 0x44, 0x55 -> full=1 after the 4th capture; after the 5th, slot0=0x55; then mode -> review=1 with led=0x22, slot_idx=1.
REQ-034 Test: continue REQ-033 with 4 capture presses in REVIEW -> led sequence 0x33, 0x44, 0x55, 0x22; sw toggling has no effect on led.
REQ-035 Test: mode press with count=0 -> review stays 0; then capture 0x0F and press mode -> REVIEW with led=0x0F, and a capture press keeps led=0x0F.
REQ-036 Test: both buttons debounced on the same cycle in LIVE with count=1 -> enters REVIEW and count stays 1; assert rst in REVIEW -> review=0, led=0, full=0 next cycle.

Source files
------------

// File: rtl/snapshot_sequencer.sv
// Snapshot sequencer: two debounced push-buttons drive a LIVE/REVIEW FSM
// that captures switch bytes into a 4-deep ring and replays them on the LEDs.
module snapshot_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_capture,
    input  logic       btn_mode,
    input  logic [7:0] sw,
    output logic [7:0] led,
    output logic [1:0] slot_idx,
    output logic       review,
    output logic       full
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {LIVE, REVIEW} state_t;

    // Button index 0 is capture, index 1 is mode.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    pulse;
    logic [CW-1:0] db_cnt [2];

    logic          cap_p;
    logic          mode_p;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    slot [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;
    logic [1:0]    wr_nxt;
    logic [1:0]    rd_nxt;
    logic [2:0]    cnt_nxt;
    logic          wr_en;
    logic [1:0]    oldest;
    logic [1:0]    newest;

    assign raw    = {btn_mode, btn_capture};
    assign cap_p  = pulse[0];
    assign mode_p = pulse[1];
    // count==4 has low bits 0, which makes the oldest slot equal wr_ptr as required.
    assign oldest = wr_ptr - count[1:0];
    assign newest = wr_ptr - 2'd1;

    // Synchronise, debounce and edge-detect both buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            pulse  <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                    pulse[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= LIVE;
        else     state <= state_nxt;
    end

    // Next state and pointer updates; mode_p outranks cap_p.
    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_ptr;
        rd_nxt    = rd_ptr;
        cnt_nxt   = count;
        wr_en     = 1'b0;
        case (state)
            LIVE: begin
                if (mode_p) begin
                    if (count != 3'd0) begin
                        state_nxt = REVIEW;
                        rd_nxt    = oldest;
                    end
                end else if (cap_p) begin
                    wr_en  = 1'b1;
                    wr_nxt = wr_ptr + 2'd1;
                    if (count != 3'd4) cnt_nxt = count + 3'd1;
                end
            end
            REVIEW: begin
                if (mode_p) begin
                    state_nxt = LIVE;
                end else if (cap_p) begin
                    rd_nxt = (rd_ptr == newest) ? oldest : rd_ptr + 2'd1;
                end
            end
            default: state_nxt = LIVE;
        endcase
    end

    // Slot storage; contents are only meaningful through count.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) slot[wr_ptr] <= sw;
    end

    // Pointers and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            led      <= '0;
            slot_idx <= '0;
            review   <= 1'b0;
            full     <= 1'b0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            count    <= cnt_nxt;
            led      <= (state_nxt == LIVE) ? sw : slot[rd_nxt];
            slot_idx <= (state_nxt == LIVE) ? wr_nxt : rd_nxt;
            review   <= (state_nxt == REVIEW);
            full     <= (cnt_nxt == 3'd4);
        end
    end

endmodule

// File: tb/tb_snapshot_sequencer.sv
// Bench for snapshot_sequencer: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_snapshot_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_capture = 1'b0;
    logic       btn_mode = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] led;
    logic [1:0] slot_idx;
    logic       review;
    logic       full;

    snapshot_sequencer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk),
        .rst(rst),
        .btn_capture(btn_capture),
        .btn_mode(btn_mode),
        .sw(sw),
        .led(led),
        .slot_idx(slot_idx),
        .review(review),
        .full(full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state
    bit         m_s1 [2];
    bit         m_s2 [2];
    bit         m_stable [2];
    bit         m_pulse [2];
    logic [N-1:0] m_win [2];
    logic [7:0] q[$];
    int         captures;
    int         ridx;
    bit         m_review;
    bit         model_ok = 1'b0;
    logic [7:0] exp_led;
    logic [1:0] exp_idx;
    logic       exp_rev;
    logic       exp_full;

    // Model: debounce as "last N synchronised samples all disagree",
    // snapshots as a queue of at most four bytes, oldest at the front.
    always @(posedge clk) begin : model
        bit raw [2];
        bit np [2];
        bit cap;
        bit mode;
        raw[0] = btn_capture;
        raw[1] = btn_mode;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_pulse[i] = 0;
                m_win[i] = '0;
            end
            q.delete();
            captures = 0; ridx = 0; m_review = 0;
            exp_led = 8'h00; exp_idx = 2'd0; exp_rev = 1'b0; exp_full = 1'b0;
            model_ok = 1'b1;
        end else begin
            cap  = m_pulse[0];
            mode = m_pulse[1];
            if (mode) begin
                if (!m_review && q.size() > 0) begin
                    m_review = 1; ridx = 0;
                end else if (m_review) begin
                    m_review = 0;
                end
            end else if (cap) begin
                if (!m_review) begin
                    q.push_back(sw);
                    if (q.size() > 4) void'(q.pop_front());
                    captures++;
                end else begin
                    ridx = (ridx + 1) % q.size();
                end
            end
            if (!m_review) begin
                exp_led = sw;
                exp_idx = 2'(captures % 4);
            end else begin
                exp_led = q[ridx];
                exp_idx = 2'((captures - q.size() + ridx) % 4);
            end
            exp_rev  = m_review;
            exp_full = (q.size() == 4);
            for (int i = 0; i < 2; i++) begin
                np[i] = 0;
                m_win[i] = {m_win[i][N-2:0], m_s2[i]};
                if (m_win[i] == {N{~m_stable[i]}}) begin
                    m_stable[i] = ~m_stable[i];
                    np[i] = m_stable[i];
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
                m_pulse[i] = np[i];
            end
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            chk("cyc_led", led, exp_led);
            chk("cyc_slot_idx", slot_idx, exp_idx);
            chk("cyc_review", review, exp_rev);
            chk("cyc_full", full, exp_full);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Checks a literal against both the DUT and the model.
    task automatic pin(input string name, input logic [31:0] act,
                       input logic [31:0] mdl, input logic [31:0] exp);
        chk({name, "_dut"}, act, exp);
        chk({name, "_model"}, mdl, exp);
    endtask

    task automatic press(input bit cap, input bit mode);
        btn_capture = cap;
        btn_mode    = mode;
        tick(N + 4);
        btn_capture = 0;
        btn_mode    = 0;
        tick(N + 5);
    endtask

    task automatic do_reset();
        rst = 1;
        tick(2);
        rst = 0;
        tick(1);
    endtask

    logic [7:0] cap_vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] rev_led  [4] = '{8'h33, 8'h44, 8'h55, 8'h22};
    logic [1:0] rev_idx  [4] = '{2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        // Reset, then live pass-through
        rst = 1; sw = 8'hA5;
        tick(3);
        pin("reset_led", led, exp_led, 8'h00);
        pin("reset_review", review, exp_rev, 0);
        pin("reset_full", full, exp_full, 0);
        rst = 0;
        tick(1);
        pin("live_led_a5", led, exp_led, 8'hA5);
        tick(2);
        pin("live_led_a5_hold", led, exp_led, 8'hA5);

        // Short glitch is rejected, long press captures once
        btn_capture = 1; tick(3); btn_capture = 0; tick(N + 6);
        pin("glitch_slot_idx", slot_idx, exp_idx, 0);
        btn_capture = 1; tick(10); btn_capture = 0; tick(N + 6);
        pin("hold_slot_idx", slot_idx, exp_idx, 1);

        // Five captures wrap the ring, then review from the oldest
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sw = cap_vals[i];
            press(1, 0);
            if (i == 3) pin("full_after_4", full, exp_full, 1);
        end
        pin("slot_idx_after_5", slot_idx, exp_idx, 1);
        sw = 8'h00;
        press(0, 1);
        pin("review_entry", review, exp_rev, 1);
        pin("review_led_oldest", led, exp_led, 8'h22);
        pin("review_idx_oldest", slot_idx, exp_idx, 1);

        // Stepping through review with sw toggling
        for (int i = 0; i < 4; i++) begin
            sw = ~sw;
            press(1, 0);
            sw = 8'hC3 ^ 8'(i);
            tick(2);
            pin("review_step_led", led, exp_led, rev_led[i]);
            pin("review_step_idx", slot_idx, exp_idx, rev_idx[i]);
        end
        pin("review_full", full, exp_full, 1);

        // Mode with nothing stored is ignored; single-slot review
        do_reset();
        press(0, 1);
        pin("empty_mode_review", review, exp_rev, 0);
        sw = 8'h0F;
        press(1, 0);
        sw = 8'h00;
        press(0, 1);
        pin("single_review", review, exp_rev, 1);
        pin("single_led", led, exp_led, 8'h0F);
        press(1, 0);
        pin("single_step_led", led, exp_led, 8'h0F);

        // Simultaneous presses: mode wins; then reset out of review
        do_reset();
        sw = 8'h77;
        press(1, 0);
        sw = 8'h99;
        press(1, 1);
        pin("both_review", review, exp_rev, 1);
        pin("both_led", led, exp_led, 8'h77);
        pin("both_idx", slot_idx, exp_idx, 0);
        pin("both_full", full, exp_full, 0);
        rst = 1;
        tick(1);
        pin("rst_review", review, exp_rev, 0);
        pin("rst_led", led, exp_led, 8'h00);
        pin("rst_full", full, exp_full, 0);
        rst = 0;
        tick(N + 4);
        pin("post_rst_live", review, exp_rev, 0);
        pin("post_rst_idx", slot_idx, exp_idx, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
